// File: rtl/ctrl_relogio.sv
// rtl/ctrl_relogio.sv - clock controller: button debounce, RUN/SET_H/SET_M mode FSM, counter enable pulses
//
// Ports:
//   ctrl_clock     in   system clock, all state on rising edge
//   ctrl_reset     in   asynchronous active-low reset
//   ctrl_tick      in   1 Hz one-cycle time base pulse
//   ctrl_btn_mode  in   raw mode button (async, active-high)
//   ctrl_btn_inc   in   raw increment button (async, active-high)
//   ctrl_sec_max   in   seconds counter holds 59
//   ctrl_min_max   in   minutes counter holds 59
//   ctrl_en_seg    out  advance seconds pulse
//   ctrl_en_min    out  advance minutes pulse
//   ctrl_en_hora   out  advance hours pulse
//   ctrl_clr_seg   out  clear seconds pulse
//   ctrl_modo      out  00 RUN, 01 SET_H, 10 SET_M
//   ctrl_blink     out  blink phase of the field being set
module ctrl_relogio #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_tick,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_inc,
  input  logic       ctrl_sec_max,
  input  logic       ctrl_min_max,
  output logic       ctrl_en_seg,
  output logic       ctrl_en_min,
  output logic       ctrl_en_hora,
  output logic       ctrl_clr_seg,
  output logic [1:0] ctrl_modo,
  output logic       ctrl_blink
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  // Counter terminal value: the level flips on the DEB_CYCLES-th differing cycle.
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

  // Bit 0 = mode button, bit 1 = inc button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  deb_q, deb_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];
  logic [1:0]  ev_q, ev_d;

  state_t state_q, state_d;
  logic   en_seg_q, en_seg_d;
  logic   en_min_q, en_min_d;
  logic   en_hora_q, en_hora_d;
  logic   clr_seg_q, clr_seg_d;
  logic   blink_q, blink_d;

  logic mode_ev, inc_ev;

  assign btn_raw = {ctrl_btn_inc, ctrl_btn_mode};
  assign mode_ev = ev_q[0];
  assign inc_ev  = ev_q[1];

  // Debounce: count consecutive cycles where the synchronized level differs
  // from the accepted level; any agreeing cycle restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    // Event is registered alongside the accepted level, so it lasts one cycle.
    ev_d = deb_d & ~deb_q;
  end

  // Next state and registered pulse outputs.
  always_comb begin
    state_d   = state_q;
    en_seg_d  = 1'b0;
    en_min_d  = 1'b0;
    en_hora_d = 1'b0;
    clr_seg_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // Tick is honoured even when mode_ev moves us out of RUN this cycle.
        if (ctrl_tick) begin
          en_seg_d  = 1'b1;
          en_min_d  = ctrl_sec_max;
          en_hora_d = ctrl_sec_max & ctrl_min_max;
        end
        if (mode_ev) state_d = ST_SET_H;
      end
      ST_SET_H: begin
        if (mode_ev)     state_d   = ST_SET_M;
        else if (inc_ev) en_hora_d = 1'b1;
      end
      ST_SET_M: begin
        if (mode_ev) begin
          state_d   = ST_RUN;
          clr_seg_d = 1'b1;
        end else if (inc_ev) begin
          en_min_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (state_d == ST_RUN)        blink_d = 1'b0;
    else if (state_d != state_q)  blink_d = 1'b1;
    else if (ctrl_tick)           blink_d = ~blink_q;
    else                          blink_d = blink_q;
  end

  always_ff @(posedge ctrl_clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      ev_q      <= '0;
      state_q   <= ST_RUN;
      en_seg_q  <= 1'b0;
      en_min_q  <= 1'b0;
      en_hora_q <= 1'b0;
      clr_seg_q <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      ev_q      <= ev_d;
      state_q   <= state_d;
      en_seg_q  <= en_seg_d;
      en_min_q  <= en_min_d;
      en_hora_q <= en_hora_d;
      clr_seg_q <= clr_seg_d;
      blink_q   <= blink_d;
    end
  end

  assign ctrl_en_seg  = en_seg_q;
  assign ctrl_en_min  = en_min_q;
  assign ctrl_en_hora = en_hora_q;
  assign ctrl_clr_seg = clr_seg_q;
  assign ctrl_modo    = state_q;
  assign ctrl_blink   = blink_q;

endmodule
